// File: rtl/button_event_arbiter.sv
// Latches one-cycle button presses and hands them one at a time to the game FSM:
// round-robin selection, valid/ready delivery, then a programmable cooldown.
module button_event_arbiter #(
  parameter int N_BTN    = 5,
  parameter int IDX_W    = 3,
  parameter int COOLDOWN = 1000,
  parameter int CNT_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_edge,
  input  logic             evt_ready,
  input  logic             clr_overflow,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_id,
  output logic [N_BTN-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    COOL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [N_BTN-1:0] pending_q;
  logic [N_BTN-1:0] pending_d;
  logic [N_BTN-1:0] grant_mask_s;
  logic             evt_valid_q;
  logic             overflow_q;
  logic             overflow_d;
  logic             busy_q;
  logic             grant_s;
  logic [IDX_W-1:0] evt_id_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] gnt_idx_s;
  logic [CNT_W-1:0] cnt_q;

  // First requesting index after 'last', wrapping from N_BTN-1 back to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(last) + k) % N_BTN;
      if (!found && req[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Grant selection and next pending/overflow; a press on the bit being granted is kept.
  always_comb begin
    grant_s      = (state_q == IDLE) && (|pending_q);
    gnt_idx_s    = rr_pick(pending_q, last_q);
    grant_mask_s = '0;
    if (grant_s) begin
      grant_mask_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_mask_s = '0;
    end
    pending_d  = (pending_q & ~grant_mask_s) | btn_edge;
    overflow_d = (|(btn_edge & pending_q & ~grant_mask_s)) | (overflow_q & ~clr_overflow);
  end

  // Arbiter FSM with its registered outputs, pending latch and cooldown counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      last_q      <= IDX_W'(N_BTN - 1);
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        IDLE: begin
          if (grant_s) begin
            evt_id_q    <= gnt_idx_s;
            evt_valid_q <= 1'b1;
            last_q      <= gnt_idx_s;
            state_q     <= OFFER;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            if (COOLDOWN > 0) begin
              cnt_q   <= CNT_W'(COOLDOWN);
              state_q <= COOL;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q <= OFFER;
          end
        end
        COOL: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Exit on the edge where the count reaches 1 so COOL spans exactly COOLDOWN cycles.
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= COOL;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule
